// File: rtl/job_sequencer_if.sv
// Bundle of run-control inputs and job-launch outputs shared between the
// job sequencer and the compute engine / run controller around it.
interface job_sequencer_if #(
  parameter int AXI_ADDR_WIDTH = 32
);
  logic                      BUTTON;
  logic                      ABORT;
  logic                      IDLE;
  logic [AXI_ADDR_WIDTH-1:0] STR_ADDR;
  logic [AXI_ADDR_WIDTH-1:0] OUT_ADDR;
  logic                      START;
  logic                      BUSY;
  logic [7:0]                JOB_INDEX;
  logic [15:0]               JOBS_DONE;
  logic                      TIMEOUT_ERR;

  // Sequencer side: drives job addresses, launch pulse and status.
  modport master (
    input  BUTTON, ABORT, IDLE,
    output STR_ADDR, OUT_ADDR, START, BUSY, JOB_INDEX, JOBS_DONE, TIMEOUT_ERR
  );

  // Engine / controller side: drives run request, abort and engine idle flag.
  modport slave (
    output BUTTON, ABORT, IDLE,
    input  STR_ADDR, OUT_ADDR, START, BUSY, JOB_INDEX, JOBS_DONE, TIMEOUT_ERR
  );
endinterface

// File: rtl/job_sequencer.sv
// Job sequencer: on a (synchronised) button press it launches NUM_JOBS jobs
// back to back on an external engine, stepping string/output addresses by a
// fixed stride per job, with a per-job watchdog and a synchronous abort.
module job_sequencer #(
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter int          NUM_JOBS       = 4,
  parameter logic [31:0] STR_BASE       = 32'hC000_0000,
  parameter logic [31:0] OUT_BASE       = 32'hC000_0100,
  parameter logic [31:0] STR_STRIDE     = 32'h0000_1000,
  parameter logic [31:0] OUT_STRIDE     = 32'h0000_1000,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input logic          clk,
  input logic          resetn,
  job_sequencer_if.master bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]           WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]                LAST_JOB = 8'(NUM_JOBS - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] STR_BASE_A   = AXI_ADDR_WIDTH'(STR_BASE);
  localparam logic [AXI_ADDR_WIDTH-1:0] OUT_BASE_A   = AXI_ADDR_WIDTH'(OUT_BASE);
  localparam logic [AXI_ADDR_WIDTH-1:0] STR_STRIDE_A = AXI_ADDR_WIDTH'(STR_STRIDE);
  localparam logic [AXI_ADDR_WIDTH-1:0] OUT_STRIDE_A = AXI_ADDR_WIDTH'(OUT_STRIDE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  // Button synchroniser and edge detector
  logic [1:0] sync_reg;
  logic [1:0] valid_reg;
  logic       prev_reg;
  logic       button_rise;

  // Sequencer state and registered outputs
  state_t                    state_reg, state_next;
  logic [WD_W-1:0]           wd_reg, wd_next;
  logic [AXI_ADDR_WIDTH-1:0] str_addr_reg, str_addr_next;
  logic [AXI_ADDR_WIDTH-1:0] out_addr_reg, out_addr_next;
  logic                      start_reg, start_next;
  logic                      busy_reg, busy_next;
  logic [7:0]                job_index_reg, job_index_next;
  logic [15:0]               jobs_done_reg, jobs_done_next;
  logic                      timeout_err_reg, timeout_err_next;

  // Two-flop synchroniser plus edge history. valid_reg marks when sync_reg[1]
  // holds a real sample; until then prev_reg is kept high so a button held
  // through reset release is not mistaken for a fresh press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_reg  <= 2'b00;
      valid_reg <= 2'b00;
      prev_reg  <= 1'b1;
    end else begin
      sync_reg  <= {sync_reg[0], bus.BUTTON};
      valid_reg <= {valid_reg[0], 1'b1};
      prev_reg  <= valid_reg[1] ? sync_reg[1] : 1'b1;
    end
  end

  assign button_rise = sync_reg[1] & ~prev_reg;

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= S_IDLE;
      wd_reg          <= '0;
      str_addr_reg    <= STR_BASE_A;
      out_addr_reg    <= OUT_BASE_A;
      start_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      job_index_reg   <= 8'd0;
      jobs_done_reg   <= 16'd0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wd_reg          <= wd_next;
      str_addr_reg    <= str_addr_next;
      out_addr_reg    <= out_addr_next;
      start_reg       <= start_next;
      busy_reg        <= busy_next;
      job_index_reg   <= job_index_next;
      jobs_done_reg   <= jobs_done_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  // Next-state and output logic; abort beats completion, completion beats timeout
  always_comb begin
    state_next       = state_reg;
    wd_next          = wd_reg;
    str_addr_next    = str_addr_reg;
    out_addr_next    = out_addr_reg;
    start_next       = 1'b0;
    busy_next        = busy_reg;
    job_index_next   = job_index_reg;
    jobs_done_next   = jobs_done_reg;
    timeout_err_next = timeout_err_reg;

    case (state_reg)
      S_IDLE: begin
        if (button_rise) begin
          state_next       = S_LAUNCH;
          job_index_next   = 8'd0;
          str_addr_next    = STR_BASE_A;
          out_addr_next    = OUT_BASE_A;
          busy_next        = 1'b1;
          timeout_err_next = 1'b0;
        end
      end

      S_LAUNCH: begin
        if (bus.ABORT) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
        end else begin
          start_next = 1'b1;
          wd_next    = '0;
          state_next = S_WAIT_ACK;
        end
      end

      S_WAIT_ACK: begin
        if (bus.ABORT) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
        end else if (wd_reg == WD_LAST) begin
          timeout_err_next = 1'b1;
          busy_next        = 1'b0;
          state_next       = S_IDLE;
        end else begin
          wd_next = wd_reg + 1'b1;
          // IDLE still high here means the engine has not picked the job up yet
          if (!bus.IDLE) begin
            state_next = S_WAIT_DONE;
          end
        end
      end

      S_WAIT_DONE: begin
        if (bus.ABORT) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
        end else if (bus.IDLE) begin
          if (jobs_done_reg != 16'hFFFF) begin
            jobs_done_next = jobs_done_reg + 16'd1;
          end
          if (job_index_reg == LAST_JOB) begin
            busy_next  = 1'b0;
            state_next = S_IDLE;
          end else begin
            job_index_next = job_index_reg + 8'd1;
            str_addr_next  = str_addr_reg + STR_STRIDE_A;
            out_addr_next  = out_addr_reg + OUT_STRIDE_A;
            state_next     = S_LAUNCH;
          end
        end else if (wd_reg == WD_LAST) begin
          timeout_err_next = 1'b1;
          busy_next        = 1'b0;
          state_next       = S_IDLE;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.STR_ADDR    = str_addr_reg;
  assign bus.OUT_ADDR    = out_addr_reg;
  assign bus.START       = start_reg;
  assign bus.BUSY        = busy_reg;
  assign bus.JOB_INDEX   = job_index_reg;
  assign bus.JOBS_DONE   = jobs_done_reg;
  assign bus.TIMEOUT_ERR = timeout_err_reg;

endmodule

// File: tb/tb_job_sequencer.sv
// Self-checking bench for job_sequencer: randomised engine latencies, aborts
// and duplicate presses, checked against a job-level reference model.
module tb_job_sequencer;

  localparam int          NJ = 4;
  localparam int          TO = 16;
  localparam logic [31:0] SB = 32'hC000_0000;
  localparam logic [31:0] OB = 32'hC000_0100;
  localparam logic [31:0] SS = 32'h0000_1000;
  localparam logic [31:0] OS = 32'h0000_1000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  job_sequencer_if #(.AXI_ADDR_WIDTH(32)) bus ();

  job_sequencer #(
    .AXI_ADDR_WIDTH(32),
    .NUM_JOBS(NJ),
    .STR_BASE(SB),
    .OUT_BASE(OB),
    .STR_STRIDE(SS),
    .OUT_STRIDE(OS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_done = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] str_of(input int j);
    return SB + SS * j;
  endfunction

  function automatic logic [31:0] out_of(input int j);
    return OB + OS * j;
  endfunction

  // Pulse BUTTON for one sampling edge N; returns just after edge N+3 where
  // the first START must be visible.
  task automatic launch_first();
    bus.BUTTON = 1'b1;
    step();
    bus.BUTTON = 1'b0;
    step();
    check_val("start_early1", bus.START, 0);
    step();
    check_val("start_early2", bus.START, 0);
    check_val("busy_accept", bus.BUSY, 1);
    check_val("terr_clear", bus.TIMEOUT_ERR, 0);
    step();
  endtask

  // One run of NJ jobs; abort_job<0 means no abort, dup requests an extra
  // button press while busy.
  task automatic do_run(input int run_id, input int abort_job, input bit dup);
    int ack;
    int work;
    launch_first();
    for (int j = 0; j < NJ; j++) begin
      check_val("start_hi", bus.START, 1);
      check_val("str_addr", bus.STR_ADDR, str_of(j));
      check_val("out_addr", bus.OUT_ADDR, out_of(j));
      check_val("job_index", bus.JOB_INDEX, j);
      check_val("busy_run", bus.BUSY, 1);
      step();
      check_val("start_once", bus.START, 0);
      ack = $urandom_range(0, 3);
      repeat (ack) step();
      bus.IDLE = 1'b0;
      work = $urandom_range(1, 6);
      for (int c = 0; c < work; c++) begin
        bus.BUTTON = (dup && j == 1 && c == 0);
        step();
        check_val("start_wait", bus.START, 0);
      end
      bus.BUTTON = 1'b0;
      bus.IDLE = 1'b1;
      if (j == abort_job) begin
        bus.ABORT = 1'b1;
        step();
        bus.ABORT = 1'b0;
        check_val("abort_busy", bus.BUSY, 0);
        check_val("abort_done", bus.JOBS_DONE, exp_done);
        check_val("abort_index", bus.JOB_INDEX, j);
        step();
        check_val("abort_nostart", bus.START, 0);
        $display("run %0d: aborted at job %0d, jobs_done=%0d", run_id, j, exp_done);
        break;
      end
      step();
      exp_done++;
      if (j == NJ - 1) begin
        check_val("end_busy", bus.BUSY, 0);
        check_val("end_done", bus.JOBS_DONE, exp_done);
        check_val("end_index", bus.JOB_INDEX, NJ - 1);
        check_val("end_str_hold", bus.STR_ADDR, str_of(NJ - 1));
        $display("run %0d: completed %0d jobs, jobs_done=%0d", run_id, NJ, exp_done);
      end else begin
        step();
      end
    end
    // No queued run from a press made while busy
    for (int k = 0; k < 5; k++) begin
      step();
      check_val("no_queue_start", bus.START, 0);
      check_val("no_queue_busy", bus.BUSY, 0);
    end
  endtask

  initial begin
    bus.BUTTON = 1'b0;
    bus.ABORT = 1'b0;
    bus.IDLE = 1'b1;
    resetn = 1'b0;
    repeat (3) step();
    check_val("rst_start", bus.START, 0);
    check_val("rst_busy", bus.BUSY, 0);
    check_val("rst_index", bus.JOB_INDEX, 0);
    check_val("rst_done", bus.JOBS_DONE, 0);
    check_val("rst_terr", bus.TIMEOUT_ERR, 0);
    check_val("rst_str", bus.STR_ADDR, SB);
    check_val("rst_out", bus.OUT_ADDR, OB);
    resetn = 1'b1;
    repeat (3) step();

    do_run(0, -1, 1'b0);
    do_run(1, 1, 1'b0);
    do_run(2, -1, 1'b1);

    // Watchdog: engine never acknowledges
    launch_first();
    check_val("to_start", bus.START, 1);
    for (int k = 1; k <= 15; k++) step();
    check_val("to_early", bus.TIMEOUT_ERR, 0);
    check_val("to_busy_early", bus.BUSY, 1);
    step();
    check_val("to_flag", bus.TIMEOUT_ERR, 1);
    check_val("to_busy", bus.BUSY, 0);
    check_val("to_done", bus.JOBS_DONE, exp_done);
    $display("timeout run: flag=%0d jobs_done=%0d", bus.TIMEOUT_ERR, bus.JOBS_DONE);
    repeat (3) step();

    for (int r = 3; r < 11; r++) begin
      int ab;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NJ - 1)) : -1;
      do_run(r, ab, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a job, button held across release
    launch_first();
    step();
    bus.IDLE = 1'b0;
    step();
    step();
    #2;
    resetn = 1'b0;
    #1;
    check_val("mid_rst_start", bus.START, 0);
    check_val("mid_rst_busy", bus.BUSY, 0);
    check_val("mid_rst_index", bus.JOB_INDEX, 0);
    check_val("mid_rst_done", bus.JOBS_DONE, 0);
    check_val("mid_rst_str", bus.STR_ADDR, SB);
    exp_done = 0;
    bus.BUTTON = 1'b1;
    bus.IDLE = 1'b1;
    step();
    step();
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check_val("held_nostart", bus.START, 0);
      check_val("held_nobusy", bus.BUSY, 0);
    end
    $display("reset mid-run: sequencer idle with button held");
    bus.BUTTON = 1'b0;
    repeat (4) step();
    do_run(11, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "bench time limit expired");
  end

endmodule
